// File: rtl/udp_reg_ring_master_pkg.sv
// Register-ring definitions shared by every ring member: bus widths,
// the no-response word and the ceiling-log2 helper used for counter sizing.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package udp_reg_ring_master_pkg;

  localparam logic [`CPCI_NF2_DATA_WIDTH-1:0] NO_RESPONSE =
    `CPCI_NF2_DATA_WIDTH'(32'hdeadbeef);

  // Bits needed to represent values 0..value-1 (minimum 0).
  function automatic int log2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/udp_reg_ring_master.sv
// Register-ring initiator: launches one host access at the ring head and
// waits for it at the tail, reporting unclaimed or timed-out accesses.
module udp_reg_ring_master
  import udp_reg_ring_master_pkg::*;
#(
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int SRC_ID            = 0,
  parameter int TIMEOUT           = 255,
  parameter int TIMEOUT_WIDTH     = log2(TIMEOUT + 1)
) (
  input  logic                            clk,
  input  logic                            reset,

  input  logic                            core_reg_req,
  input  logic                            core_reg_rd_wr_L,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
  output logic                            core_reg_busy,
  output logic                            core_reg_ack,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
  output logic                            core_reg_timeout,

  output logic                            reg_req_out,
  output logic                            reg_ack_out,
  output logic                            reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_out,

  input  logic                            reg_req_in,
  input  logic                            reg_ack_in,
  input  logic                            reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]    reg_src_in,

  output logic [7:0]                      stray_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG     = UDP_REG_SRC_WIDTH'(SRC_ID);
  localparam logic [TIMEOUT_WIDTH-1:0]     TIMEOUT_END = TIMEOUT_WIDTH'(TIMEOUT);

  state_t                            state, state_next;
  logic                              rd_wr_q;
  logic [`UDP_REG_ADDR_WIDTH-1:0]    addr_q;
  logic [`CPCI_NF2_DATA_WIDTH-1:0]   wr_data_q;
  logic [TIMEOUT_WIDTH-1:0]          wait_count;
  logic [`CPCI_NF2_DATA_WIDTH-1:0]   result_q;
  logic                              timed_out_q;

  logic                              accept;
  logic                              stray;
  logic                              finish;
  logic [`CPCI_NF2_DATA_WIDTH-1:0]   finish_data;
  logic                              finish_timeout;

  // Returns only travel back on the tail; their address and direction are not needed.
  logic unused_tail;
  assign unused_tail = ^{reg_addr_in, reg_rd_wr_L_in};

  assign accept = reg_req_in && (reg_src_in == SRC_TAG);
  assign stray  = reg_req_in && !((state == WAIT) && accept);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rd_wr_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wait_count  <= '0;
      result_q    <= '0;
      timed_out_q <= 1'b0;
      stray_count <= 8'd0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && core_reg_req) begin
        rd_wr_q   <= core_reg_rd_wr_L;
        addr_q    <= core_reg_addr;
        wr_data_q <= core_reg_wr_data;
      end
      if (state == ISSUE)
        wait_count <= '0;
      else if (state == WAIT)
        wait_count <= wait_count + 1'b1;
      if (finish) begin
        result_q    <= finish_data;
        timed_out_q <= finish_timeout;
      end
      if (stray && (stray_count != 8'hff))
        stray_count <= stray_count + 8'd1;
    end
  end

  // A matching return is checked before the timeout so it wins a same-cycle tie.
  always_comb begin
    state_next      = state;
    finish          = 1'b0;
    finish_data     = NO_RESPONSE;
    finish_timeout  = 1'b1;
    reg_req_out     = 1'b0;
    reg_ack_out     = 1'b0;
    reg_rd_wr_L_out = 1'b0;
    reg_addr_out    = '0;
    reg_data_out    = '0;
    reg_src_out     = '0;
    case (state)
      IDLE: begin
        if (core_reg_req)
          state_next = ISSUE;
      end
      ISSUE: begin
        reg_req_out     = 1'b1;
        reg_rd_wr_L_out = rd_wr_q;
        reg_addr_out    = addr_q;
        reg_data_out    = rd_wr_q ? '0 : wr_data_q;
        reg_src_out     = SRC_TAG;
        state_next      = WAIT;
      end
      WAIT: begin
        if (accept) begin
          finish = 1'b1;
          if (reg_ack_in) begin
            finish_data    = reg_data_in;
            finish_timeout = 1'b0;
          end
        end else if (wait_count == TIMEOUT_END) begin
          finish = 1'b1;
        end
        if (finish)
          state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign core_reg_busy    = (state != IDLE);
  assign core_reg_ack     = (state == DONE);
  assign core_reg_timeout = (state == DONE) && timed_out_q;
  assign core_reg_rd_data = result_q;

endmodule

// File: tb/tb_udp_reg_ring_master.sv
// Scoreboard bench: a three-stage ring with one slave window drives the master;
// host accesses push expected results that a negedge monitor pops on each ack.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_udp_reg_ring_master;

  localparam int AW         = `UDP_REG_ADDR_WIDTH;
  localparam int DW         = `CPCI_NF2_DATA_WIDTH;
  localparam int SW         = 2;
  localparam int SRC_ID     = 1;
  localparam int TIMEOUT    = 16;
  localparam int RING_DEPTH = 3;
  localparam logic [SW-1:0] SRC_TAG = SW'(SRC_ID);
  localparam logic [DW-1:0] NO_RESP = 32'hdeadbeef;

  typedef struct packed {
    logic          req;
    logic          ack;
    logic          rd_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } ring_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          timeout;
    int            latency;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_reg_req = 1'b0;
  logic          core_reg_rd_wr_L = 1'b1;
  logic [AW-1:0] core_reg_addr = '0;
  logic [DW-1:0] core_reg_wr_data = '0;
  logic          core_reg_busy, core_reg_ack, core_reg_timeout;
  logic [DW-1:0] core_reg_rd_data;
  logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [DW-1:0] reg_data_out;
  logic [SW-1:0] reg_src_out;
  logic          reg_req_in, reg_ack_in, reg_rd_wr_L_in;
  logic [AW-1:0] reg_addr_in;
  logic [DW-1:0] reg_data_in;
  logic [SW-1:0] reg_src_in;
  logic [7:0]    stray_count;

  udp_reg_ring_master #(
    .UDP_REG_SRC_WIDTH(SW),
    .SRC_ID(SRC_ID),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .core_reg_req(core_reg_req), .core_reg_rd_wr_L(core_reg_rd_wr_L),
    .core_reg_addr(core_reg_addr), .core_reg_wr_data(core_reg_wr_data),
    .core_reg_busy(core_reg_busy), .core_reg_ack(core_reg_ack),
    .core_reg_rd_data(core_reg_rd_data), .core_reg_timeout(core_reg_timeout),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out),
    .reg_rd_wr_L_out(reg_rd_wr_L_out), .reg_addr_out(reg_addr_out),
    .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in),
    .reg_rd_wr_L_in(reg_rd_wr_L_in), .reg_addr_in(reg_addr_in),
    .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int ack_count = 0;
  bit mon_en = 1'b0;
  bit prev_req = 1'b0;

  exp_t  resp_q[$];
  ring_t head_q[$];

  // Ring environment: slave owns 0x400000..0x40001F, three registered stages.
  bit            mem_init = 1'b1;
  bit            break_ring = 1'b0;
  bit            inj = 1'b0;
  ring_t         inj_pkt = '0;
  ring_t         head, slave_resp, stage0, stage1, stage2, tail;
  logic [DW-1:0] slave_mem [32];
  logic [DW-1:0] ref_mem [32];

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 16) ? 32'h12345678 : (32'hC0DE_0000 + DW'(i));
  endfunction

  function automatic bit owned(input logic [AW-1:0] a);
    return a[AW-1:5] == 18'h20000;
  endfunction

  assign head = {reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out};

  always_comb begin
    slave_resp = head;
    if (break_ring) slave_resp = '0;
    else if (head.req && owned(head.addr)) begin
      slave_resp.ack  = 1'b1;
      slave_resp.data = head.rd_wr ? slave_mem[head.addr[4:0]] : head.data;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int i = 0; i < 32; i++) slave_mem[i] <= init_word(i);
      stage0 <= '0; stage1 <= '0; stage2 <= '0;
    end else begin
      if (head.req && !break_ring && owned(head.addr) && !head.rd_wr)
        slave_mem[head.addr[4:0]] <= head.data;
      stage0 <= slave_resp;
      stage1 <= stage0;
      stage2 <= stage1;
    end
  end

  assign tail           = inj ? inj_pkt : stage2;
  assign reg_req_in     = tail.req;
  assign reg_ack_in     = tail.ack;
  assign reg_rd_wr_L_in = tail.rd_wr;
  assign reg_addr_in    = tail.addr;
  assign reg_data_in    = tail.data;
  assign reg_src_in     = tail.src;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: ring head contents, one-cycle request, and acks against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_req) check_output("req_one_cycle", 64'(reg_req_out), 64'd0);
      if (reg_req_out) begin
        issue_cyc = cyc;
        if (head_q.size() == 0) check_output("head_unexpected", 64'(head), 64'd0);
        else check_output("head_contents", 64'(head), 64'(head_q.pop_front()));
      end else begin
        check_output("head_idle_zero", 64'(head), 64'd0);
      end
      prev_req = reg_req_out;
      if (core_reg_ack) begin
        ack_count++;
        if (resp_q.size() == 0) begin
          check_output("ack_unexpected", 64'(core_reg_ack), 64'd0);
        end else begin
          exp_t e;
          e = resp_q.pop_front();
          check_output("ack_rd_data", 64'(core_reg_rd_data), 64'(e.data));
          check_output("ack_timeout", 64'(core_reg_timeout), 64'(e.timeout));
          check_output("ack_latency", 64'(cyc - issue_cyc), 64'(e.latency));
        end
      end else begin
        check_output("timeout_without_ack", 64'(core_reg_timeout), 64'd0);
      end
    end
  end

  task automatic apply_stimulus(input logic rd_wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input bit expect_resp);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (core_reg_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (core_reg_busy) begin
      check_output("busy_release", 64'(core_reg_busy), 64'd0);
      return;
    end
    head_q.push_back({1'b1, 1'b0, rd_wr, addr, rd_wr ? DW'(0) : data, SRC_TAG});
    if (expect_resp) begin
      if (break_ring) e = '{NO_RESP, 1'b1, TIMEOUT + 2};
      else if (!owned(addr)) e = '{NO_RESP, 1'b1, RING_DEPTH + 1};
      else if (rd_wr) e = '{ref_mem[addr[4:0]], 1'b0, RING_DEPTH + 1};
      else begin
        ref_mem[addr[4:0]] = data;
        e = '{data, 1'b0, RING_DEPTH + 1};
      end
      resp_q.push_back(e);
    end
    core_reg_req     = 1'b1;
    core_reg_rd_wr_L = rd_wr;
    core_reg_addr    = addr;
    core_reg_wr_data = data;
    @(negedge clk);
    core_reg_req = 1'b0;
  endtask

  task automatic wait_ack(input int start_count);
    int guard;
    guard = 0;
    while (ack_count == start_count && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_output("ack_arrived", 64'(ack_count - start_count), 64'd1);
  endtask

  task automatic inject_return(input logic [SW-1:0] src, input logic ack, input logic [DW-1:0] data);
    @(negedge clk);
    inj     = 1'b1;
    inj_pkt = {1'b1, ack, 1'b1, AW'(0), data, src};
    @(negedge clk);
    inj = 1'b0;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check_output({tag, "_busy"}, 64'(core_reg_busy), 64'd0);
    check_output({tag, "_ack"}, 64'(core_reg_ack), 64'd0);
    check_output({tag, "_timeout"}, 64'(core_reg_timeout), 64'd0);
    check_output({tag, "_rd_data"}, 64'(core_reg_rd_data), 64'd0);
    check_output({tag, "_stray"}, 64'(stray_count), 64'd0);
    check_output({tag, "_head"}, 64'(head), 64'd0);
  endtask

  initial begin
    int base_acks;
    int base_stray;
    logic [AW-1:0] a;

    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    check_quiet_outputs("reset");
    reset = 1'b1;
    mon_en = 1'b1;

    $display("[TB] directed read of 0x400010");
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h400010, 32'h0, 1'b1);
    wait_ack(base_acks);

    $display("[TB] directed write to 0x400004");
    base_acks = ack_count;
    apply_stimulus(1'b0, 23'h400004, 32'hA5A5A5A5, 1'b1);
    wait_ack(base_acks);

    $display("[TB] unclaimed address");
    base_stray = stray_count;
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h123456, 32'h0, 1'b1);
    wait_ack(base_acks);
    check_output("unclaimed_stray", 64'(stray_count), 64'(base_stray));

    $display("[TB] broken ring timeout then late return");
    break_ring = 1'b1;
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h400008, 32'h0, 1'b1);
    wait_ack(base_acks);
    base_stray = stray_count;
    inject_return(SRC_TAG, 1'b1, 32'h0BAD0BAD);
    repeat (5) @(negedge clk);
    check_output("late_return_stray", 64'(stray_count), 64'(base_stray + 1));
    check_output("late_return_no_ack", 64'(ack_count), 64'(base_acks + 1));
    break_ring = 1'b0;

    $display("[TB] request during WAIT and mismatched source");
    base_stray = stray_count;
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h400003, 32'h0, 1'b1);
    @(negedge clk);
    inj = 1'b1;
    inj_pkt = {1'b1, 1'b1, 1'b1, AW'(0), 32'h77777777, SRC_TAG ^ 2'b11};
    core_reg_req = 1'b1;
    core_reg_addr = 23'h400011;
    @(negedge clk);
    inj = 1'b0;
    core_reg_req = 1'b0;
    wait_ack(base_acks);
    repeat (6) @(negedge clk);
    check_output("wait_req_single_ack", 64'(ack_count), 64'(base_acks + 1));
    check_output("mismatch_stray", 64'(stray_count), 64'(base_stray + 1));

    $display("[TB] reset during WAIT");
    break_ring = 1'b1;
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h400010, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_quiet_outputs("mid_reset");
    reset = 1'b1;
    inject_return(SRC_TAG, 1'b1, 32'h12345678);
    check_output("post_reset_stray", 64'(stray_count), 64'd1);
    repeat (TIMEOUT + 6) @(negedge clk);
    check_output("post_reset_no_ack", 64'(ack_count), 64'(base_acks));
    break_ring = 1'b0;
    base_acks = ack_count;
    apply_stimulus(1'b1, 23'h400010, 32'h0, 1'b1);
    wait_ack(base_acks);

    $display("[TB] randomized accesses");
    base_stray = stray_count;
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      a = {18'h20000, 5'($urandom_range(0, 31))};
      if (kind >= 7) begin
        a = AW'($urandom);
        if (owned(a)) a[AW-1] = 1'b0;
      end
      break_ring = (kind == 0);
      base_acks = ack_count;
      apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, 1'b1);
      wait_ack(base_acks);
      break_ring = 1'b0;
    end
    check_output("random_no_stray", 64'(stray_count), 64'(base_stray));
    check_output("scoreboard_drained", 64'(resp_q.size() + head_q.size()), 64'd0);

    $display("[TB] stray counter saturation");
    @(negedge clk);
    inj = 1'b1;
    inj_pkt = {1'b1, 1'b0, 1'b1, AW'(0), DW'(0), SRC_TAG ^ 2'b01};
    repeat (300) @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    check_output("stray_saturates", 64'(stray_count), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
